mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares the single memory request/response port between icache and dcache.
- Fixed-priority arbitration: dcache writeback > dcache load/store > icache fetch/prefetch. Winner is registered onto the memory port with a valid/ready handshake.
- Read responses (in memory order) are routed back to the issuing cache via an in-order source-tag FIFO.
- Per-requester backpressure is driven through mem_full_icache / mem_full_dcache.

Parameters:
ADDR_W, 32, address width (word)
LINE_BITS, 128, line payload width (LINE_SIZE*32)
QDEPTH, 4, outstanding-read tag FIFO depth (power of 2, >=2)
STARVE_MAX, 4, consecutive icache losses before forced icache grant (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
icache_req_valid  in  1  icache read request
icache_req_addr  in  ADDR_W  line address
dcache_req_valid  in  1  dcache request
dcache_req_addr  in  ADDR_W  address
dcache_req_data  in  LINE_BITS  write payload
dcache_req_store  in  1  store write (no response)
dcache_writeback  in  1  dirty-line writeback (no response)
mem_full_icache  out  1  icache request not accepted this cycle
mem_full_dcache  out  1  dcache request not accepted this cycle
mem_req_valid  out  1  request to memory
mem_req_addr  out  ADDR_W
mem_req_data  out  LINE_BITS
mem_req_write  out  1  1=write, 0=read
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  read data returning (in order)
mem_resp_addr  in  ADDR_W
mem_resp_data  in  LINE_BITS
icache_resp_valid  out  1
dcache_resp_valid  out  1
resp_addr  out  ADDR_W  shared response address
resp_data  out  LINE_BITS  shared response data
resp_err  out  1  sticky: response with empty tag FIFO

Behaviour:
- Reset: all outputs 0; output register empty; tag FIFO empty; starvation counter 0; resp_err cleared.
- Slot free when !mem_req_valid || mem_req_ready.
- Read eligible only if tag count < QDEPTH. Count is the registered value; a same-cycle pop does not free space.
- Write (writeback or store) eligible whenever the slot is free. A write never enqueues a tag.
- Grant order: dcache (writeback or store or read) first, then icache. Only one grant per cycle.
- Loser or ineligible requester sees mem_full_* = 1 in the same cycle, combinationally. Requesters hold and retry; the arbiter does not buffer losers.
- Granted request loads the output register next cycle: mem_req_valid=1; addr/data/write held stable until mem_req_ready.
- mem_req_data is 0 for reads.
- Read grant pushes a source tag (0=icache, 1=dcache) in the grant cycle.
- Tag FIFO: head/tail pointers of $clog2(QDEPTH) bits wrap modulo QDEPTH; separate count register.
- Response path is registered, 1-cycle latency:
  - mem_resp_valid pops the head.
  - Next cycle, exactly one of icache_resp_valid / dcache_resp_valid is asserted, per the tag.
  - resp_addr/resp_data = captured mem_resp_*.
- Response with an empty FIFO: dropped, no resp valid, resp_err set until reset.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset mid-transaction: outstanding tags discarded. Responses arriving after reset then set resp_err.
- Area: no combinational path from mem_resp_* to mem_req_*.

Optional Feature:
MEM_ARB_STARVE_EN
- Defined:
  - 3-bit counter increments each cycle icache_req_valid loses to dcache.
  - Counter clears on any icache grant or when icache_req_valid=0.
  - At STARVE_MAX, icache wins the next eligible cycle over dcache loads/stores. Writebacks still win.
- Undefined: strict priority; counter absent; icache may starve indefinitely.

Test Plan:
- icache read 0x100 alone, mem_req_ready=1 -> mem_req_valid cycle+1 addr 0x100 write=0; resp 0x100 data 0xAA.. -> icache_resp_valid one cycle later, dcache_resp_valid=0.
- icache 0x200 + dcache writeback 0x300 same cycle -> dcache granted (write=1), mem_full_icache=1; next cycle icache granted; no tag for writeback, one response routed to icache.
- 4 dcache reads, no responses, QDEPTH=4 -> 5th read sees mem_full_dcache=1; one response pops -> 5th accepted following cycle; store accepted while full.
- mem_req_ready=0 for 3 cycles with pending request -> addr/data stable, mem_full_* =1 for new requests, release on ready.
- mem_resp_valid with empty FIFO -> no resp valids, resp_err=1 sticky until rst.
- MEM_ARB_STARVE_EN, STARVE_MAX=4: continuous dcache loads + icache request -> icache granted on 5th cycle; with continuous writebacks icache never granted.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one memory request/response port between the icache and dcache.
//   Fixed priority: dcache writeback/store/load first, then icache.
//   The winner is registered onto the memory port and held until
//   mem_req_ready. Read responses return in memory order and are steered
//   back to the issuing cache through an in-order source-tag FIFO.
//
// Optional feature (compile-time macro MEM_ARB_STARVE_EN):
//   A 3-bit starvation counter tracks consecutive icache losses to the
//   dcache. Once it reaches STARVE_MAX (must be <= 7), icache beats dcache
//   loads/stores on its next eligible cycle; writebacks still win.
//   Without the macro, arbitration is strict priority.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   icache_req_valid/addr            icache line read request
//   dcache_req_valid/addr/data       dcache request (read unless store/writeback)
//   dcache_req_store, dcache_writeback  write qualifiers (no response)
//   mem_full_icache/dcache           request not accepted this cycle
//   mem_req_valid/addr/data/write    registered request to memory
//   mem_req_ready                    memory accepts the request
//   mem_resp_valid/addr/data         in-order read data from memory
//   icache_resp_valid/dcache_resp_valid  routed response strobes
//   resp_addr/resp_data              shared response payload
//   resp_err                         sticky: response arrived with no tag

module mem_req_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BITS  = 128,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 icache_req_valid,
  input  logic [ADDR_W-1:0]    icache_req_addr,
  input  logic                 dcache_req_valid,
  input  logic [ADDR_W-1:0]    dcache_req_addr,
  input  logic [LINE_BITS-1:0] dcache_req_data,
  input  logic                 dcache_req_store,
  input  logic                 dcache_writeback,
  output logic                 mem_full_icache,
  output logic                 mem_full_dcache,
  output logic                 mem_req_valid,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [LINE_BITS-1:0] mem_req_data,
  output logic                 mem_req_write,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [ADDR_W-1:0]    mem_resp_addr,
  input  logic [LINE_BITS-1:0] mem_resp_data,
  output logic                 icache_resp_valid,
  output logic                 dcache_resp_valid,
  output logic [ADDR_W-1:0]    resp_addr,
  output logic [LINE_BITS-1:0] resp_data,
  output logic                 resp_err
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  // request output register
  logic                 req_vld_p1;
  logic [ADDR_W-1:0]    req_addr_p1;
  logic [LINE_BITS-1:0] req_data_p1;
  logic                 req_wr_p1;

  // tag FIFO (0 = icache, 1 = dcache)
  logic [QDEPTH-1:0]    tag_mem;
  logic [PTR_W-1:0]     head_ptr;
  logic [PTR_W-1:0]     tail_ptr;
  logic [CNT_W-1:0]     tag_cnt;

  // response register
  logic                 rsp_ic_vld_p1;
  logic                 rsp_dc_vld_p1;
  logic [ADDR_W-1:0]    rsp_addr_p1;
  logic [LINE_BITS-1:0] rsp_data_p1;
  logic                 rsp_err_p1;

  logic slot_free_p0, rd_ok_p0, dc_wr_p0, dc_elig_p0, ic_elig_p0;
  logic gnt_dc_p0, gnt_ic_p0, push_p0, pop_p0;

`ifdef MEM_ARB_STARVE_EN
  logic [2:0] starve_cnt;
  logic       starve_force_p0;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction
`endif

  // ---- stage p0: eligibility and arbitration ----
  // Read eligibility uses the registered tag count only, so a response
  // popping this cycle never frees space for a same-cycle read and there is
  // no combinational path from mem_resp_* into the request side.
  always_comb begin
    slot_free_p0 = !req_vld_p1 || mem_req_ready;
    rd_ok_p0     = tag_cnt < CNT_W'(QDEPTH);
    dc_wr_p0     = dcache_writeback || dcache_req_store;
    dc_elig_p0   = dcache_req_valid && slot_free_p0 && (dc_wr_p0 || rd_ok_p0);
    ic_elig_p0   = icache_req_valid && slot_free_p0 && rd_ok_p0;
`ifdef MEM_ARB_STARVE_EN
    starve_force_p0 = (starve_cnt >= 3'(STARVE_MAX)) &&
                      !(dcache_req_valid && dcache_writeback);
    gnt_ic_p0 = ic_elig_p0 && (!dc_elig_p0 || starve_force_p0);
    gnt_dc_p0 = dc_elig_p0 && !gnt_ic_p0;
`else
    gnt_dc_p0 = dc_elig_p0;
    gnt_ic_p0 = ic_elig_p0 && !dc_elig_p0;
`endif
    push_p0 = gnt_ic_p0 || (gnt_dc_p0 && !dc_wr_p0);
    pop_p0  = mem_resp_valid && (tag_cnt != '0);
  end

  assign mem_full_icache = icache_req_valid && !gnt_ic_p0;
  assign mem_full_dcache = dcache_req_valid && !gnt_dc_p0;

`ifdef MEM_ARB_STARVE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!icache_req_valid || gnt_ic_p0) begin
      starve_cnt <= '0;
    end else if (gnt_dc_p0) begin
      starve_cnt <= sat_inc3(starve_cnt);
    end
  end
`endif

  // ---- stage p1: request output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_p1  <= 1'b0;
      req_addr_p1 <= '0;
      req_data_p1 <= '0;
      req_wr_p1   <= 1'b0;
    end else if (gnt_dc_p0 || gnt_ic_p0) begin
      req_vld_p1  <= 1'b1;
      req_addr_p1 <= gnt_dc_p0 ? dcache_req_addr : icache_req_addr;
      req_data_p1 <= (gnt_dc_p0 && dc_wr_p0) ? dcache_req_data : '0;
      req_wr_p1   <= gnt_dc_p0 && dc_wr_p0;
    end else if (mem_req_ready) begin
      req_vld_p1  <= 1'b0;
    end
  end

  assign mem_req_valid = req_vld_p1;
  assign mem_req_addr  = req_addr_p1;
  assign mem_req_data  = req_data_p1;
  assign mem_req_write = req_wr_p1;

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      tag_cnt  <= '0;
    end else begin
      if (push_p0) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop_p0)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push_p0, pop_p0})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) tag_mem[tail_ptr] <= gnt_dc_p0;
  end

  // ---- stage p1: response register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_ic_vld_p1 <= 1'b0;
      rsp_dc_vld_p1 <= 1'b0;
      rsp_addr_p1   <= '0;
      rsp_data_p1   <= '0;
      rsp_err_p1    <= 1'b0;
    end else begin
      rsp_ic_vld_p1 <= pop_p0 && !tag_mem[head_ptr];
      rsp_dc_vld_p1 <= pop_p0 &&  tag_mem[head_ptr];
      if (mem_resp_valid) begin
        rsp_addr_p1 <= mem_resp_addr;
        rsp_data_p1 <= mem_resp_data;
      end
      if (mem_resp_valid && (tag_cnt == '0)) rsp_err_p1 <= 1'b1;
    end
  end

  assign icache_resp_valid = rsp_ic_vld_p1;
  assign dcache_resp_valid = rsp_dc_vld_p1;
  assign resp_addr         = rsp_addr_p1;
  assign resp_data         = rsp_data_p1;
  assign resp_err          = rsp_err_p1;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed vectors; expected memory requests
// and routed responses go into queues, and a negedge monitor pops and
// compares them whenever the DUT presents a handshake or response strobe.

module tb_mem_req_arbiter;

  localparam int ADDR_W     = 32;
  localparam int LINE_BITS  = 128;
  localparam int QDEPTH     = 4;
  localparam int STARVE_MAX = 4;

  logic                 clk;
  logic                 rst;
  logic                 icache_req_valid;
  logic [ADDR_W-1:0]    icache_req_addr;
  logic                 dcache_req_valid;
  logic [ADDR_W-1:0]    dcache_req_addr;
  logic [LINE_BITS-1:0] dcache_req_data;
  logic                 dcache_req_store;
  logic                 dcache_writeback;
  logic                 mem_full_icache;
  logic                 mem_full_dcache;
  logic                 mem_req_valid;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic [LINE_BITS-1:0] mem_req_data;
  logic                 mem_req_write;
  logic                 mem_req_ready;
  logic                 mem_resp_valid;
  logic [ADDR_W-1:0]    mem_resp_addr;
  logic [LINE_BITS-1:0] mem_resp_data;
  logic                 icache_resp_valid;
  logic                 dcache_resp_valid;
  logic [ADDR_W-1:0]    resp_addr;
  logic [LINE_BITS-1:0] resp_data;
  logic                 resp_err;

  mem_req_arbiter #(
    .ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .dcache_req_valid(dcache_req_valid), .dcache_req_addr(dcache_req_addr),
    .dcache_req_data(dcache_req_data), .dcache_req_store(dcache_req_store),
    .dcache_writeback(dcache_writeback),
    .mem_full_icache(mem_full_icache), .mem_full_dcache(mem_full_dcache),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_write(mem_req_write),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_addr(mem_resp_addr),
    .mem_resp_data(mem_resp_data),
    .icache_resp_valid(icache_resp_valid), .dcache_resp_valid(dcache_resp_valid),
    .resp_addr(resp_addr), .resp_data(resp_data), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [LINE_BITS-1:0] data;
    logic                 wr;
  } req_t;

  typedef struct packed {
    logic                 is_d;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_BITS-1:0] data;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  int checks   = 0;
  int failures = 0;

  localparam logic [LINE_BITS-1:0] D_AA = {4{32'hAAAA_AAAA}};
  localparam logic [LINE_BITS-1:0] D_WB = {4{32'h1234_5678}};
  localparam logic [LINE_BITS-1:0] D_BB = {4{32'hBBBB_0000}};
  localparam logic [LINE_BITS-1:0] D_ST = {4{32'h5A5A_C3C3}};

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icache_req_valid = 1'b0; icache_req_addr  = '0;
    dcache_req_valid = 1'b0; dcache_req_addr  = '0; dcache_req_data = '0;
    dcache_req_store = 1'b0; dcache_writeback = 1'b0;
    mem_resp_valid   = 1'b0; mem_resp_addr    = '0; mem_resp_data   = '0;
  endtask

  task automatic exp_q(input logic [ADDR_W-1:0] a, input logic [LINE_BITS-1:0] d, input logic w);
    req_t r;
    r.addr = a; r.data = d; r.wr = w;
    exp_req.push_back(r);
  endtask

  task automatic exp_r(input logic is_d, input logic [ADDR_W-1:0] a, input logic [LINE_BITS-1:0] d);
    rsp_t s;
    s.is_d = is_d; s.addr = a; s.data = d;
    exp_rsp.push_back(s);
  endtask

  task automatic dc_req(input logic [ADDR_W-1:0] a, input logic [LINE_BITS-1:0] d,
                        input logic st, input logic wb);
    dcache_req_valid = 1'b1; dcache_req_addr = a; dcache_req_data = d;
    dcache_req_store = st; dcache_writeback = wb;
  endtask

  task automatic dc_off();
    dcache_req_valid = 1'b0; dcache_req_store = 1'b0; dcache_writeback = 1'b0;
  endtask

  task automatic resp(input logic [ADDR_W-1:0] a, input logic [LINE_BITS-1:0] d);
    mem_resp_valid = 1'b1; mem_resp_addr = a; mem_resp_data = d;
  endtask

  // Monitor: compare every accepted memory request and every routed response.
  req_t mr;
  rsp_t ms;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        checks++;
        if (exp_req.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected: got addr=%0h wr=%0b expected none", mem_req_addr, mem_req_write);
        end else begin
          mr = exp_req.pop_front();
          if (mem_req_addr !== mr.addr || mem_req_data !== mr.data || mem_req_write !== mr.wr) begin
            failures++;
            $display("FAIL req_match: got addr=%0h data=%0h wr=%0b expected addr=%0h data=%0h wr=%0b",
                     mem_req_addr, mem_req_data, mem_req_write, mr.addr, mr.data, mr.wr);
          end
        end
      end
      if (icache_resp_valid || dcache_resp_valid) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got ic=%0b dc=%0b addr=%0h expected none",
                   icache_resp_valid, dcache_resp_valid, resp_addr);
        end else begin
          ms = exp_rsp.pop_front();
          if ({icache_resp_valid, dcache_resp_valid} !== (ms.is_d ? 2'b01 : 2'b10) ||
              resp_addr !== ms.addr || resp_data !== ms.data) begin
            failures++;
            $display("FAIL rsp_match: got ic=%0b dc=%0b addr=%0h data=%0h expected dcache=%0b addr=%0h data=%0h",
                     icache_resp_valid, dcache_resp_valid, resp_addr, resp_data, ms.is_d, ms.addr, ms.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_req_ready = 1'b1;
    idle();
    adv();
    @(negedge clk);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_icache_resp", icache_resp_valid, 1'b0);
    chk1("rst_dcache_resp", dcache_resp_valid, 1'b0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk1("rst_full_i", mem_full_icache, 1'b0);
    chk1("rst_full_d", mem_full_dcache, 1'b0);
    adv();
    rst = 1'b0;
    adv();

    // single icache read and its response
    icache_req_valid = 1'b1; icache_req_addr = 32'h100;
    @(negedge clk);
    chk1("t1_full_i", mem_full_icache, 1'b0);
    exp_q(32'h100, '0, 1'b0);
    adv();
    icache_req_valid = 1'b0;
    @(negedge clk);
    chk1("t1_req_valid", mem_req_valid, 1'b1);
    resp(32'h100, D_AA);
    exp_r(1'b0, 32'h100, D_AA);
    adv();
    mem_resp_valid = 1'b0;
    adv();

    // icache vs dcache writeback in the same cycle
    icache_req_valid = 1'b1; icache_req_addr = 32'h200;
    dc_req(32'h300, D_WB, 1'b0, 1'b1);
    @(negedge clk);
    chk1("t2_full_i", mem_full_icache, 1'b1);
    chk1("t2_full_d", mem_full_dcache, 1'b0);
    exp_q(32'h300, D_WB, 1'b1);
    adv();
    dc_off();
    @(negedge clk);
    chk1("t2_full_i_retry", mem_full_icache, 1'b0);
    exp_q(32'h200, '0, 1'b0);
    adv();
    icache_req_valid = 1'b0;
    resp(32'h200, D_BB);
    exp_r(1'b0, 32'h200, D_BB);
    adv();
    mem_resp_valid = 1'b0;
    adv();

    // fill the tag FIFO with dcache reads
    for (int i = 0; i < QDEPTH; i++) begin
      dc_req(32'h1000 + 32'(i * 16), '1, 1'b0, 1'b0);
      @(negedge clk);
      chk1("t3_fill_full_d", mem_full_dcache, 1'b0);
      exp_q(32'h1000 + 32'(i * 16), '0, 1'b0);
      adv();
    end
    dc_req(32'h1040, '1, 1'b0, 1'b0);
    @(negedge clk);
    chk1("t3_fifo_full_d", mem_full_dcache, 1'b1);
    adv();
    resp(32'h1000, D_AA);
    exp_r(1'b1, 32'h1000, D_AA);
    @(negedge clk);
    chk1("t3_pop_same_cycle_full_d", mem_full_dcache, 1'b1);
    adv();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk1("t3_after_pop_full_d", mem_full_dcache, 1'b0);
    exp_q(32'h1040, '0, 1'b0);
    adv();
    dc_req(32'h2000, D_ST, 1'b1, 1'b0);
    @(negedge clk);
    chk1("t3_store_while_full", mem_full_dcache, 1'b0);
    exp_q(32'h2000, D_ST, 1'b1);
    adv();
    dc_off();
    for (int i = 1; i <= QDEPTH; i++) begin
      resp(32'h1000 + 32'(i * 16), D_BB ^ 128'(i));
      exp_r(1'b1, 32'h1000 + 32'(i * 16), D_BB ^ 128'(i));
      adv();
    end
    mem_resp_valid = 1'b0;
    adv();

    // memory backpressure for three cycles
    mem_req_ready = 1'b0;
    dc_req(32'h3000, '1, 1'b0, 1'b0);
    exp_q(32'h3000, '0, 1'b0);
    adv();
    dc_req(32'h3100, D_WB, 1'b0, 1'b1);
    icache_req_valid = 1'b1; icache_req_addr = 32'h3200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("t4_stall_full_i", mem_full_icache, 1'b1);
      chk1("t4_stall_full_d", mem_full_dcache, 1'b1);
      chka("t4_stall_addr", mem_req_addr, 32'h3000);
      chk1("t4_stall_valid", mem_req_valid, 1'b1);
      adv();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk1("t4_release_full_d", mem_full_dcache, 1'b0);
    chk1("t4_release_full_i", mem_full_icache, 1'b1);
    exp_q(32'h3100, D_WB, 1'b1);
    adv();
    dc_off();
    @(negedge clk);
    chk1("t4_icache_after", mem_full_icache, 1'b0);
    exp_q(32'h3200, '0, 1'b0);
    adv();
    icache_req_valid = 1'b0;
    resp(32'h3000, D_AA); exp_r(1'b1, 32'h3000, D_AA);
    adv();
    resp(32'h3200, D_ST); exp_r(1'b0, 32'h3200, D_ST);
    adv();
    mem_resp_valid = 1'b0;
    adv();
    chk1("t5_err_before", resp_err, 1'b0);

    // response with an empty tag FIFO
    resp(32'hDEAD, D_AA);
    adv();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk1("t5_err_set", resp_err, 1'b1);
    chk1("t5_no_ic", icache_resp_valid, 1'b0);
    chk1("t5_no_dc", dcache_resp_valid, 1'b0);
    adv(); adv();
    chk1("t5_err_sticky", resp_err, 1'b1);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk1("t5_err_cleared", resp_err, 1'b0);
    adv();

    // reset with a read outstanding discards its tag
    icache_req_valid = 1'b1; icache_req_addr = 32'h4000;
    exp_q(32'h4000, '0, 1'b0);
    adv();
    icache_req_valid = 1'b0;
    adv();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    resp(32'h4000, D_AA);
    adv();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk1("t6_err_after_rst", resp_err, 1'b1);
    chk1("t6_no_ic", icache_resp_valid, 1'b0);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    adv();

`ifdef MEM_ARB_STARVE_EN
    // starvation relief against stores, none against writebacks
    icache_req_valid = 1'b1; icache_req_addr = 32'h5000;
    for (int i = 0; i < STARVE_MAX; i++) begin
      dc_req(32'h6000 + 32'(i), D_ST, 1'b1, 1'b0);
      @(negedge clk);
      chk1("s_lose_full_i", mem_full_icache, 1'b1);
      exp_q(32'h6000 + 32'(i), D_ST, 1'b1);
      adv();
    end
    dc_req(32'h6100, D_ST, 1'b1, 1'b0);
    @(negedge clk);
    chk1("s_force_full_i", mem_full_icache, 1'b0);
    chk1("s_force_full_d", mem_full_dcache, 1'b1);
    exp_q(32'h5000, '0, 1'b0);
    adv();
    icache_req_valid = 1'b0;
    exp_q(32'h6100, D_ST, 1'b1);
    adv();
    icache_req_valid = 1'b1; icache_req_addr = 32'h5100;
    for (int i = 0; i < 6; i++) begin
      dc_req(32'h7000 + 32'(i), D_WB, 1'b0, 1'b1);
      @(negedge clk);
      chk1("s_wb_full_i", mem_full_icache, 1'b1);
      exp_q(32'h7000 + 32'(i), D_WB, 1'b1);
      adv();
    end
    dc_off();
    exp_q(32'h5100, '0, 1'b0);
    adv();
    icache_req_valid = 1'b0;
    resp(32'h5000, D_AA); exp_r(1'b0, 32'h5000, D_AA);
    adv();
    resp(32'h5100, D_BB); exp_r(1'b0, 32'h5100, D_BB);
    adv();
    mem_resp_valid = 1'b0;
    adv();
`endif

    adv(); adv();
    chka("req_queue_drained", 32'(exp_req.size()), 32'd0);
    chka("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
